digipot_spi_ctrl: RTL and testbench
===================================

# digipot_spi_ctrl

Parametrised SPI write controller for the board's digital potentiometers, sitting between the control logic and the shared SCLK/MOSI bus with one chip select per device. It takes a word, a target index and a start pulse, then shifts the word out MSB-first in SPI mode 0 with a programmable clock divider. It reports busy, done and error, and enforces a minimum chip-select high time between frames. Optional read-back captures MISO during the same frame.

## Interface
- DATA_W, 8: bits per frame.
- NUM_CS, 3: number of chip-select outputs (1..16).
- SEL_W, 2: width of `sel`; must satisfy 2^SEL_W >= NUM_CS.
- CLK_DIV, 2: SCLK half-period in `clk` cycles (>= 1); SCLK = clk/(2*CLK_DIV), 12.5 MHz at 50 MHz default.
- clk  in  1  global clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- sel  in  SEL_W  target device index, latched with `start`.
- data  in  DATA_W  word to send, latched with `start`.
- busy  out  1  high from the cycle after an accepted `start` until the end of GUARD.
- done  out  1  one-cycle pulse at the end of a frame.
- err  out  1  one-cycle pulse when `start` arrives with `sel >= NUM_CS`.
- cs_n  out  NUM_CS  active-low chip selects; at most one bit is low.
- sclk  out  1  serial clock, idle low.
- mosi  out  1  serial data, idle low.
- miso  in  1  serial data in (used only with DIGIPOT_SPI_READBACK_EN).
- rdata  out  DATA_W  captured word (only with DIGIPOT_SPI_READBACK_EN).

## Operation
- All outputs are registered. Reset values: cs_n all ones, sclk 0, mosi 0, busy 0, done 0, err 0, rdata 0. The FSM resets to IDLE.
- IDLE: on `start` with a valid sel, latch data and sel, set busy and go to SETUP. With an invalid sel, pulse err for one cycle, leave busy low and stay in IDLE.
- SETUP (CLK_DIV cycles): cs_n[sel] is low and mosi = data[DATA_W-1].
- SHIFT (DATA_W bits, 2*CLK_DIV cycles per bit):
  - sclk is low for the first CLK_DIV cycles of each bit, then high for CLK_DIV cycles.
  - mosi changes only on the sclk falling edge, i.e. the first cycle of the next bit.
  - With read-back, miso is sampled into the shift register on each sclk rising edge.
- HOLD (CLK_DIV cycles): sclk low, cs_n still low, mosi holds the last bit.
- On exiting HOLD:
  - cs_n returns to all ones and mosi goes to 0.
  - done pulses for one cycle.
  - rdata is updated in the same cycle (read-back only).
  - The FSM enters GUARD.
- GUARD (CLK_DIV cycles): busy stays high and `start` is ignored. The FSM then returns to IDLE.
- `start` while busy is ignored (no queueing) and does not raise err.
- A change to `data` or `sel` mid-frame has no effect, because both are latched.
- Asserting `rst` mid-frame immediately forces all reset values. No done pulse is produced, and the partial frame is abandoned.

## Timing
- Take `start` sampled at edge 0. Then:
  - cs_n goes low after edge 1.
  - The first sclk rise is at edge 1+2*CLK_DIV.
  - cs_n stays low for 2*CLK_DIV*(DATA_W+1) cycles; this is 36 cycles at the defaults.
- done is high in the first cycle cs_n is all ones. busy falls CLK_DIV cycles later.
- Minimum spacing between two accepted starts is 2*CLK_DIV*(DATA_W+1)+CLK_DIV+1 cycles; this is 39 at the defaults.
- err pulses in the cycle after the invalid `start`.

## Configuration
- DIGIPOT_SPI_READBACK_EN defined:
  - The `miso` and `rdata` ports exist.
  - MISO is shifted in MSB-first on sclk rising edges.
  - rdata updates together with done and holds until the next done or reset.
- Not defined:
  - `miso` and `rdata` are absent and no capture logic is built.
  - All other timing is identical.

## Test plan
- Reset, then start with sel=1, data=0xA5 at the defaults -> only cs_n[1] low for 36 cycles, 8 sclk rises, mosi sampled on rises = 1,0,1,0,0,1,0,1, one done pulse.
- start with sel=3 (NUM_CS=3) -> err high for 1 cycle, cs_n stays 3'b111, busy stays 0.
- Second start 1 cycle after done, then another at 3 cycles after done -> the first is ignored; the second is accepted and cs_n falls on the next edge.
- DATA_W=16, CLK_DIV=4, data=0x8001 -> 16 sclk periods of 8 cycles each, cs_n low for 136 cycles, mosi = 1, then fourteen 0s, then 1.
- rst pulsed at sclk rise 4 of a frame -> cs_n all ones, sclk 0 and busy 0 immediately, no done; the next start produces a complete frame.
- With DIGIPOT_SPI_READBACK_EN, a bench slave drives miso=0x3C -> rdata=0x3C in the done cycle.

Source files
------------

// File: rtl/digipot_spi_ctrl.sv
// digipot_spi_ctrl: SPI mode-0 write controller for the board's digital
// potentiometers. Shifts one DATA_W-bit word MSB-first to the device picked
// by `sel`, then holds chip select high for a guard time.
// Optional MISO read-back is built when DIGIPOT_SPI_READBACK_EN is defined.
//
// Stage p0 holds the frame state (phase, cycle counter, bit index).
// Stage p1 holds the registered bus outputs decoded from stage p0, so
// cs_n/sclk/mosi/done trail the state by one clock. busy is the exception:
// it rises in the cycle after an accepted start.
module digipot_spi_ctrl #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 3,
  parameter int SEL_W   = 2,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUM_CS-1:0] cs_n,
  output logic              sclk,
  output logic              mosi
`ifdef DIGIPOT_SPI_READBACK_EN
  ,
  input  logic              miso,
  output logic [DATA_W-1:0] rdata
`endif
);

  localparam int CNT_W = $clog2(2*CLK_DIV+1);
  localparam int BIT_W = $clog2(DATA_W+1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV-1);
  localparam logic [CNT_W-1:0] RISE      = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2*CLK_DIV-1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W-1);
  localparam logic [SEL_W:0]   NUM_CS_V  = (SEL_W+1)'(NUM_CS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GUARD} state_t;

  state_t             state_p0, state_nxt;
  logic [CNT_W-1:0]   cnt_p0, cnt_nxt;
  logic [BIT_W-1:0]   bidx_p0, bidx_nxt;
  logic               accept, reject, bit_end;
  logic               frame_act;
  logic [SEL_W-1:0]   sel_p0;
  logic [DATA_W-1:0]  sh_p0;
  logic [NUM_CS-1:0]  cs_nxt;

  // Next-state logic: phase sequencing and cycle/bit counting
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    bidx_nxt  = bidx_p0;
    accept    = 1'b0;
    reject    = 1'b0;
    bit_end   = 1'b0;
    unique case (state_p0)
      IDLE: begin
        if (start) begin
          if ({1'b0, sel} < NUM_CS_V) begin
            accept    = 1'b1;
            state_nxt = SETUP;
            cnt_nxt   = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_p0 == HALF_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          bidx_nxt  = '0;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_p0 == BIT_LAST) begin
          bit_end = 1'b1;
          cnt_nxt = '0;
          if (bidx_p0 == LAST_BIT) state_nxt = HOLD;
          else                     bidx_nxt  = bidx_p0 + BIT_W'(1);
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_p0 == HALF_LAST) begin
          state_nxt = GUARD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      GUARD: begin
        if (cnt_p0 == HALF_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_act = state_p0 inside {SETUP, SHIFT, HOLD};

  // Chip-select decode: only the latched target goes low while a frame is active
  always_comb begin
    cs_nxt = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (frame_act && (sel_p0 == SEL_W'(i))) cs_nxt[i] = 1'b0;
    end
  end

  // Stage p0 -> p1: state register and registered bus/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      bidx_p0  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cs_n     <= '1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      bidx_p0  <= bidx_nxt;
      busy     <= accept | (state_p0 != IDLE);
      done     <= (state_p0 == GUARD) && (cnt_p0 == '0);
      err      <= reject;
      cs_n     <= cs_nxt;
      sclk     <= (state_p0 == SHIFT) && (cnt_p0 >= RISE);
      mosi     <= frame_act & sh_p0[DATA_W-1];
    end
  end

  // Stage p0 datapath: latch target and word on accept, shift after each bit
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_p0 <= sel;
      sh_p0  <= data;
    end else if (bit_end && (bidx_p0 != LAST_BIT)) begin
      sh_p0 <= sh_p0 << 1;
    end
  end

`ifdef DIGIPOT_SPI_READBACK_EN
  logic [DATA_W-1:0] rx_p0;

  // Stage p0 capture: sample miso on the clock edge that raises sclk
  always_ff @(posedge clk) begin
    if ((state_p0 == SHIFT) && (cnt_p0 == RISE)) rx_p0 <= {rx_p0[DATA_W-2:0], miso};
  end

  // Stage p1 read-back word: published together with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          rdata <= '0;
    else if ((state_p0 == GUARD) && (cnt_p0 == '0)) rdata <= rx_p0;
  end
`endif

endmodule

// File: tb/tb_digipot_spi_ctrl.sv
// tb_digipot_spi_ctrl: directed and randomized bench for digipot_spi_ctrl.
// Expected frames are derived from the frame timing rules (chip-select
// window, sclk rise positions, MSB-first bits, done/busy positions).
// Define DIGIPOT_SPI_READBACK_EN to also exercise MISO read-back.
module tb_digipot_spi_ctrl;

  localparam int DATA_W  = 8;
  localparam int NUM_CS  = 3;
  localparam int SEL_W   = 2;
  localparam int CLK_DIV = 2;

  localparam int LOW_LEN      = 2*CLK_DIV*(DATA_W+1);
  localparam int DONE_C       = 1 + LOW_LEN;
  localparam int BUSY_FALL_C  = DONE_C + CLK_DIV;
  localparam int FIRST_RISE_C = 1 + 2*CLK_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] data;
  logic              busy, done, err;
  logic [NUM_CS-1:0] cs_n;
  logic              sclk, mosi;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

`ifdef DIGIPOT_SPI_READBACK_EN
  logic              miso;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] slv_pat = '0;
  int                slv_cnt = 0;
  logic              cs_hi;

  // Bench slave: presents pattern MSB-first, advancing on sclk falling edges
  assign cs_hi = &cs_n;
  assign miso  = (slv_cnt < DATA_W) ? slv_pat[DATA_W-1-slv_cnt] : 1'b0;
  always @(negedge sclk or posedge cs_hi) begin
    if (cs_hi) slv_cnt = 0;
    else       slv_cnt = slv_cnt + 1;
  end
`endif

  always #5 clk = ~clk;

  digipot_spi_ctrl #(
    .DATA_W(DATA_W), .NUM_CS(NUM_CS), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .data(data),
    .busy(busy), .done(done), .err(err), .cs_n(cs_n), .sclk(sclk), .mosi(mosi)
`ifdef DIGIPOT_SPI_READBACK_EN
    , .miso(miso), .rdata(rdata)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full frame from start to the last busy cycle; returns at sample BUSY_FALL_C-1
  task automatic do_frame(input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d,
                          input bit noise, input bit poke_guard, input string tag);
    logic [NUM_CS-1:0] exp_cs;
    logic [DATA_W-1:0] got_bits;
    logic [63:0]       c0_obs;
    logic              prev_sclk, prev_mosi, setup_mosi, done_quiet;
    int cs_low_cnt, first_low, bad_cs, rises, first_rise, last_rise, bad_gap;
    int done_cnt, done_c, err_cnt, busy_lo, bad_mosi;
`ifdef DIGIPOT_SPI_READBACK_EN
    logic [DATA_W-1:0] got_rd = '0;
`endif
    exp_cs = ~(NUM_CS'(1) << s);
    got_bits = '0; c0_obs = '0; setup_mosi = 1'b0; done_quiet = 1'b0;
    cs_low_cnt = 0; first_low = -1; bad_cs = 0; rises = 0; first_rise = -1;
    last_rise = -1; bad_gap = 0; done_cnt = 0; done_c = -1; err_cnt = 0;
    busy_lo = 0; bad_mosi = 0;
    prev_sclk = 1'b0; prev_mosi = 1'b0;
    sel = s; data = d; start = 1'b1;
    for (int c = 0; c < BUSY_FALL_C; c++) begin
      @(negedge clk);
      if (c == 0) c0_obs = 64'({busy, err, done, sclk, mosi, cs_n});
      if (cs_n !== '1) begin
        cs_low_cnt++;
        if (first_low < 0) begin
          first_low  = c;
          setup_mosi = mosi;
        end
        if (cs_n !== exp_cs) bad_cs++;
      end
      if (sclk && !prev_sclk) begin
        if (rises < DATA_W) got_bits = {got_bits[DATA_W-2:0], mosi};
        if (first_rise < 0) first_rise = c;
        else if (c - last_rise != 2*CLK_DIV) bad_gap++;
        last_rise = c;
        rises++;
      end
      if ((mosi !== prev_mosi) && !(prev_sclk && !sclk) && (c != 1) && (c != DONE_C)) bad_mosi++;
      if (done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c     = c;
          done_quiet = (mosi === 1'b0) && (sclk === 1'b0) && (cs_n === '1);
`ifdef DIGIPOT_SPI_READBACK_EN
          got_rd = rdata;
`endif
        end
      end
      if (err)   err_cnt++;
      if (!busy) busy_lo++;
      prev_sclk = sclk;
      prev_mosi = mosi;
      // inputs for the next edge
      start = 1'b0;
      if (noise && (c < LOW_LEN - 4)) begin
        start = 1'($urandom_range(0, 1));
        sel   = SEL_W'($urandom);
        data  = DATA_W'($urandom);
      end
      if (poke_guard && (c == DONE_C)) begin
        start = 1'b1;
        sel   = s;
      end
    end
    start = 1'b0;
    check({tag, "_first_cycle"}, c0_obs, 64'({1'b1, 4'b0, {NUM_CS{1'b1}}}));
    check({tag, "_cs_fall_cycle"}, 64'(first_low), 64'(1));
    check({tag, "_cs_low_len"}, 64'(cs_low_cnt), 64'(LOW_LEN));
    check({tag, "_cs_pattern_bad"}, 64'(bad_cs), 64'(0));
    check({tag, "_setup_mosi"}, 64'(setup_mosi), 64'(d[DATA_W-1]));
    check({tag, "_sclk_rises"}, 64'(rises), 64'(DATA_W));
    check({tag, "_first_rise"}, 64'(first_rise), 64'(FIRST_RISE_C));
    check({tag, "_rise_gap_bad"}, 64'(bad_gap), 64'(0));
    check({tag, "_mosi_bits"}, 64'(got_bits), 64'(d));
    check({tag, "_mosi_change_bad"}, 64'(bad_mosi), 64'(0));
    check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    check({tag, "_done_cycle"}, 64'(done_c), 64'(DONE_C));
    check({tag, "_done_quiet"}, 64'(done_quiet), 64'(1));
    check({tag, "_err_count"}, 64'(err_cnt), 64'(0));
    check({tag, "_busy_low"}, 64'(busy_lo), 64'(0));
`ifdef DIGIPOT_SPI_READBACK_EN
    check({tag, "_rdata_at_done"}, 64'(got_rd), 64'(slv_pat));
    check({tag, "_rdata_hold"}, 64'(rdata), 64'(slv_pat));
`endif
  endtask

  // Cycle after the last busy cycle: bus idle, busy low
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle"}, 64'({busy, done, err, sclk, mosi, cs_n}), 64'({5'b0, {NUM_CS{1'b1}}}));
  endtask

  // Start with an out-of-range select: one err pulse, nothing else moves
  task automatic do_bad(input logic [SEL_W-1:0] s, input string tag);
    sel = s; data = DATA_W'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err_pulse"}, 64'({busy, err, done, cs_n}), 64'({3'b010, {NUM_CS{1'b1}}}));
    @(negedge clk);
    check({tag, "_err_gone"}, 64'({busy, err, done, cs_n}), 64'({3'b000, {NUM_CS{1'b1}}}));
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic              prev;
    int                r, dcnt, blo;

    rst = 1'b1; start = 1'b0; sel = '0; data = '0;
`ifdef DIGIPOT_SPI_READBACK_EN
    slv_pat = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, err, sclk, mosi, cs_n}), 64'({5'b0, {NUM_CS{1'b1}}}));
`ifdef DIGIPOT_SPI_READBACK_EN
    check("reset_rdata", 64'(rdata), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'({busy, done, err, sclk, mosi, cs_n}), 64'({5'b0, {NUM_CS{1'b1}}}));

    // Basic frame: sel 1, 0xA5
`ifdef DIGIPOT_SPI_READBACK_EN
    slv_pat = DATA_W'('h3C);
`endif
    do_frame(SEL_W'(1), DATA_W'('hA5), 1'b0, 1'b0, "a5");
    idle_check("a5");

    // Out-of-range select
    do_bad(SEL_W'(3), "badsel");

    // Only MSB and LSB set
    d = '0; d[DATA_W-1] = 1'b1; d[0] = 1'b1;
`ifdef DIGIPOT_SPI_READBACK_EN
    slv_pat = DATA_W'($urandom);
`endif
    do_frame(SEL_W'(0), d, 1'b0, 1'b0, "ends");
    idle_check("ends");

    // start one cycle after done is ignored; start three cycles after done is taken
    do_frame(SEL_W'(2), DATA_W'($urandom), 1'b1, 1'b1, "poke");
    idle_check("poke_ignored");
    do_frame(SEL_W'(1), DATA_W'($urandom), 1'b0, 1'b0, "after_poke");

    // Back-to-back at the minimum start spacing
    do_frame(SEL_W'(0), DATA_W'($urandom), 1'b0, 1'b0, "b2b");
    idle_check("b2b");

    // Reset at the fourth sclk rise abandons the frame
    sel = SEL_W'(2); data = DATA_W'($urandom); start = 1'b1;
    r = 0; prev = 1'b0;
    for (int c = 0; (c < 200) && (r < 4); c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sclk && !prev) r++;
      prev = sclk;
    end
    check("rst_rise4_reached", 64'(r), 64'(4));
    #1 rst = 1'b1;
    #1;
    check("rst_async_outputs", 64'({busy, done, err, sclk, mosi, cs_n}), 64'({5'b0, {NUM_CS{1'b1}}}));
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0; blo = 0;
    for (int c = 0; c < DONE_C + 4; c++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy || (cs_n !== '1)) blo++;
    end
    check("rst_no_done", 64'(dcnt), 64'(0));
    check("rst_stays_idle", 64'(blo), 64'(0));
`ifdef DIGIPOT_SPI_READBACK_EN
    slv_pat = DATA_W'($urandom);
`endif
    do_frame(SEL_W'(1), DATA_W'($urandom), 1'b0, 1'b0, "after_rst");
    idle_check("after_rst");

    // Randomized frames with mid-frame input churn and occasional bad selects
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_bad(SEL_W'($urandom_range(NUM_CS, (1 << SEL_W) - 1)), $sformatf("rnd%0d_bad", k));
      end else begin
`ifdef DIGIPOT_SPI_READBACK_EN
        slv_pat = DATA_W'($urandom);
`endif
        do_frame(SEL_W'($urandom_range(0, NUM_CS - 1)), DATA_W'($urandom), 1'b1, 1'b0,
                 $sformatf("rnd%0d", k));
        idle_check($sformatf("rnd%0d", k));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
